// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access with req/ack handshake, timeout and MEM/WB register
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteM,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] qbM,
  input  logic [4:0]  dstregM,
  input  logic [2:0]  wtypeM,
  output logic        stallM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        regwriteW,
  output logic        memtoregW,
  output logic [31:0] ALUoutW,
  output logic [31:0] memdataW,
  output logic [4:0]  dstregW,
  output logic        alignErrW,
  output logic        busErrW
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] memdata_q, memdata_d;
  logic [4:0]  dstreg_q, dstreg_d;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;

  logic        is_half, is_byte, is_word, memop, misal;
  logic [3:0]  be_raw;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_fmt;

  always_comb begin
    is_half = (wtypeM == 3'b001) || (wtypeM == 3'b010);
    is_byte = (wtypeM == 3'b011) || (wtypeM == 3'b100);
    is_word = !is_half && !is_byte;
    memop   = memtoregM || memwriteM;
    misal   = (is_word && (ALUoutM[1:0] != 2'b00)) || (is_half && ALUoutM[0]);

    if (is_byte) begin
      be_raw   = 4'b0001 << ALUoutM[1:0];
      dm_wdata = {4{qbM[7:0]}};
    end else if (is_half) begin
      be_raw   = ALUoutM[1] ? 4'b1100 : 4'b0011;
      dm_wdata = {2{qbM[15:0]}};
    end else begin
      be_raw   = 4'b1111;
      dm_wdata = qbM;
    end

    case (ALUoutM[1:0])
      2'd0:    byte_lane = dm_rdata[7:0];
      2'd1:    byte_lane = dm_rdata[15:8];
      2'd2:    byte_lane = dm_rdata[23:16];
      default: byte_lane = dm_rdata[31:24];
    endcase
    half_lane = ALUoutM[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    case (wtypeM)
      3'b001:  load_fmt = {{16{half_lane[15]}}, half_lane};
      3'b010:  load_fmt = {16'h0000, half_lane};
      3'b011:  load_fmt = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_fmt = {24'h000000, byte_lane};
      default: load_fmt = dm_rdata;
    endcase
  end

  // Stalled cycles load a bubble: control bits clear, data fields hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stallM      = 1'b0;
    regwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    aluout_d    = aluout_q;
    memdata_d   = memdata_q;
    dstreg_d    = dstreg_q;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (memop && !misal) begin
          stallM  = 1'b1;
          state_d = S_ACCESS;
        end else begin
          regwrite_d  = regwriteM && !memop;
          memtoreg_d  = memtoregM;
          aluout_d    = ALUoutM;
          memdata_d   = 32'h0;
          dstreg_d    = dstregM;
          align_err_d = memop;
        end
      end
      default: begin
        if (dm_ack) begin
          regwrite_d = regwriteM;
          memtoreg_d = memtoregM;
          aluout_d   = ALUoutM;
          memdata_d  = memtoregM ? load_fmt : 32'h0;
          dstreg_d   = dstregM;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          memtoreg_d = memtoregM;
          aluout_d   = ALUoutM;
          memdata_d  = 32'h0;
          dstreg_d   = dstregM;
          bus_err_d  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          stallM = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      aluout_q    <= 32'h0;
      memdata_q   <= 32'h0;
      dstreg_q    <= 5'd0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      aluout_q    <= aluout_d;
      memdata_q   <= memdata_d;
      dstreg_q    <= dstreg_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign dm_req    = (state_q == S_ACCESS);
  assign dm_we     = dm_req && memwriteM;
  assign dm_addr   = {ALUoutM[31:2], 2'b00};
  assign dm_be     = dm_req ? be_raw : 4'b0000;
  assign regwriteW = regwrite_q;
  assign memtoregW = memtoreg_q;
  assign ALUoutW   = aluout_q;
  assign memdataW  = memdata_q;
  assign dstregW   = dstreg_q;
  assign alignErrW = align_err_q;
  assign busErrW   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural memory-op model
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwriteM, memtoregM, memwriteM;
  logic [31:0] ALUoutM, qbM;
  logic [4:0]  dstregM;
  logic [2:0]  wtypeM;
  logic        stallM, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        regwriteW, memtoregW;
  logic [31:0] ALUoutW, memdataW;
  logic [4:0]  dstregW;
  logic        alignErrW, busErrW;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .ALUoutM(ALUoutM), .qbM(qbM), .dstregM(dstregM), .wtypeM(wtypeM),
    .stallM(stallM), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .regwriteW(regwriteW), .memtoregW(memtoregW), .ALUoutW(ALUoutW),
    .memdataW(memdataW), .dstregW(dstregW), .alignErrW(alignErrW), .busErrW(busErrW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  dst;
    logic        ae;
    logic        be;
  } wexp_t;

  wexp_t expq[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wexp_t mk(input logic rw, input logic mtr, input logic [31:0] alu,
                               input logic [31:0] md, input logic [4:0] dst,
                               input logic ae, input logic be);
    wexp_t e;
    e.rw = rw; e.mtr = mtr; e.alu = alu; e.md = md; e.dst = dst; e.ae = ae; e.be = be;
    return e;
  endfunction

  function automatic int width_of(input logic [2:0] wt);
    if (wt == 3'd1 || wt == 3'd2) return 2;
    if (wt == 3'd3 || wt == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic model_misal(input logic [2:0] wt, input logic [31:0] a);
    return (a % width_of(wt)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] wt, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    logic sign_ext;
    n = width_of(wt);
    v = rd >> (8 * (a % 4));
    if (n == 4) return rd;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = v & mask;
    sign_ext = (wt == 3'd1 || wt == 3'd3) && v[8*n-1];
    return sign_ext ? (v | ~mask) : v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] wt, input logic [31:0] a);
    int n;
    n = width_of(wt);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] wt, input logic [31:0] qb);
    int n;
    logic [31:0] r;
    n = width_of(wt);
    r = 32'h0;
    for (int i = 0; i < 4 / n; i++)
      r = r | ((qb & ((32'h1 << (8 * n)) - 32'h1 | {32{n == 4}})) << (8 * n * i));
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && (regwriteW || alignErrW || busErrW)) begin
      if (expq.size() == 0) begin
        check("w_unexpected_event", {29'h0, regwriteW, alignErrW, busErrW}, 32'h0);
      end else begin
        wexp_t e;
        e = expq.pop_front();
        check("regwriteW", regwriteW, e.rw);
        check("alignErrW", alignErrW, e.ae);
        check("busErrW", busErrW, e.be);
        check("ALUoutW", ALUoutW, e.alu);
        check("dstregW", dstregW, e.dst);
        if (e.rw) begin
          check("memtoregW", memtoregW, e.mtr);
          check("memdataW", memdataW, e.md);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that retires the op.
  task automatic do_op(input logic ld, input logic st, input logic rw, input logic [31:0] a,
                       input logic [31:0] qb, input logic [4:0] dst, input logic [2:0] wt,
                       input int k, input logic [31:0] rd);
    int stalls, reqs;
    logic ack;
    memtoregM = ld; memwriteM = st; regwriteM = rw;
    ALUoutM = a; qbM = qb; dstregM = dst; wtypeM = wt; dm_ack = 1'b0;
    if (!(ld || st) || model_misal(wt, a)) begin
      dm_ack = 1'($urandom_range(0, 1));
      dm_rdata = $urandom;
      @(negedge clk);
      check("nostall_stallM", stallM, 1'b0);
      check("nostall_dm_req", dm_req, 1'b0);
      if (ld || st) expq.push_back(mk(1'b0, ld, a, 32'h0, dst, 1'b1, 1'b0));
      else if (rw)  expq.push_back(mk(1'b1, 1'b0, a, 32'h0, dst, 1'b0, 1'b0));
      @(posedge clk); #1;
      dm_ack = 1'b0;
      return;
    end
    stalls = 0; reqs = 0;
    @(negedge clk);
    check("entry_stallM", stallM, 1'b1);
    check("entry_dm_req", dm_req, 1'b0);
    if (stallM) stalls++;
    @(posedge clk); #1;
    for (int c = 0; c < TIMEOUT; c++) begin
      ack = (c == k);
      dm_ack = ack;
      dm_rdata = ack ? rd : $urandom;
      @(negedge clk);
      if (stallM) stalls++;
      if (dm_req) reqs++;
      check("acc_dm_req", dm_req, 1'b1);
      check("acc_dm_we", dm_we, st);
      check("acc_dm_addr", dm_addr, a & 32'hFFFF_FFFC);
      check("acc_dm_be", dm_be, st ? model_be(wt, a) : dm_be);
      if (st) check("acc_dm_wdata", dm_wdata, model_wdata(wt, qb));
      check("acc_stallM", stallM, !(ack || c == TIMEOUT - 1));
      if (ack) begin
        if (rw) expq.push_back(mk(1'b1, ld, a, ld ? model_load(wt, a, rd) : 32'h0, dst, 1'b0, 1'b0));
        break;
      end
      if (c == TIMEOUT - 1) begin
        expq.push_back(mk(1'b0, ld, a, 32'h0, dst, 1'b0, 1'b1));
        break;
      end
      @(posedge clk); #1;
    end
    check("stall_cycles", stalls, (k < TIMEOUT) ? k + 1 : TIMEOUT);
    check("req_cycles", reqs, (k < TIMEOUT) ? k + 1 : TIMEOUT);
    @(posedge clk); #1;
    dm_ack = 1'b0;
  endtask

  task automatic idle_inputs();
    regwriteM = 1'b0; memtoregM = 1'b0; memwriteM = 1'b0;
    ALUoutM = 32'h0; qbM = 32'h0; dstregM = 5'd0; wtypeM = 3'd0;
    dm_ack = 1'b0; dm_rdata = 32'h0;
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, "_regwriteW"}, regwriteW, 1'b0);
    check({tag, "_memtoregW"}, memtoregW, 1'b0);
    check({tag, "_ALUoutW"}, ALUoutW, 32'h0);
    check({tag, "_memdataW"}, memdataW, 32'h0);
    check({tag, "_dstregW"}, dstregW, 5'd0);
    check({tag, "_errs"}, {alignErrW, busErrW}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dm_req", dm_req, 1'b0);
    check("rst_stallM", stallM, 1'b0);
    check("rst_dm_be", dm_be, 4'b0000);
    check_w_zero("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(1, 0, 1, 32'h100, 32'h0, 5'd3, 3'b000, 2, 32'hDEADBEEF);
    do_op(0, 1, 0, 32'h203, 32'h000000A5, 5'd0, 3'b011, 1, 32'h0);
    do_op(1, 0, 1, 32'h102, 32'h0, 5'd4, 3'b001, 0, 32'h8001F00F);
    do_op(1, 0, 1, 32'h102, 32'h0, 5'd5, 3'b010, 3, 32'h8001F00F);
    do_op(1, 0, 1, 32'h101, 32'h0, 5'd6, 3'b000, 0, 32'h0);
    do_op(0, 0, 1, 32'h1234, 32'h0, 5'd7, 3'b000, 0, 32'h0);
    do_op(1, 0, 1, 32'h300, 32'h0, 5'd8, 3'b000, TIMEOUT, 32'h0);
    do_op(1, 0, 1, 32'h304, 32'h0, 5'd9, 3'b100, TIMEOUT - 1, 32'h11223344);
    do_op(0, 1, 0, 32'h402, 32'h0000BEEF, 5'd0, 3'b010, 0, 32'h0);

    // reset while a load is waiting for its ack
    regwriteM = 1'b1; memtoregM = 1'b1; memwriteM = 1'b0;
    ALUoutM = 32'h500; dstregM = 5'd10; wtypeM = 3'b000; dm_ack = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("pre_rst_dm_req", dm_req, 1'b1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_dm_req", dm_req, 1'b0);
    check("midrst_stallM", stallM, 1'b0);
    check_w_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("stray_dm_req", dm_req, 1'b0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    check("stray_memdataW", memdataW, 32'h0);
    check("stray_memtoregW", memtoregW, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      int kind, k;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      k = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 5);
      case (kind)
        0, 3: do_op(1, 0, 1, a, 32'h0, 5'($urandom), 3'($urandom), k, $urandom);
        1:    do_op(0, 1, 0, a, $urandom, 5'($urandom), 3'($urandom), k, 32'h0);
        default: do_op(0, 0, 1'($urandom), a, $urandom, 5'($urandom), 3'($urandom), 0, 32'h0);
      endcase
    end

    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EXE/MEM pipeline register outputs. Turns the M-stage control and data (ALU result as the address, rs/rt data as store data, width type) into a request/acknowledge transaction on the data-memory port. It formats load data and stalls the upstream pipeline while a transaction is outstanding. It owns the MEM/WB register feeding writeback.

Parameters:
TIMEOUT, 16, maximum cycles in ACCESS without dm_ack before the request is abandoned (legal range 2..255)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
regwriteM  in  1  M-stage register-write enable
memtoregM  in  1  M-stage load
memwriteM  in  1  M-stage store (memtoregM and memwriteM never both 1)
ALUoutM  in  32  byte address or ALU result
qbM  in  32  store data
dstregM  in  5  destination register
wtypeM  in  3  width: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; others are treated as word
stallM  out  1  freeze PC, IF/ID, ID/EXE, EXE/MEM (combinational)
dm_req  out  1  memory request, held until ack or timeout
dm_we  out  1  1 = store
dm_addr  out  32  {ALUoutM[31:2],2'b00}
dm_be  out  4  byte enables
dm_wdata  out  32  lane-replicated store data
dm_ack  in  1  one-cycle completion; qualifies dm_rdata
dm_rdata  in  32  load word
regwriteW  out  1  WB write enable
memtoregW  out  1  WB selects memdataW
ALUoutW  out  32  registered ALUoutM
memdataW  out  32  formatted load data
dstregW  out  5  registered dstregM
alignErrW  out  1  one-cycle pulse: misaligned access dropped
busErrW  out  1  one-cycle pulse: access timed out

Behaviour:
- memop = memtoregM|memwriteM. misal = (word & ALUoutM[1:0]!=0) | (half & ALUoutM[0]).
- FSM states: IDLE, ACCESS. A 8-bit wait counter cnt runs only in ACCESS.
- IDLE:
  - memop & ~misal: stallM=1; next state ACCESS, cnt<=0.
  - memop & misal: no request, stallM=0; W takes the op with regwriteW=0, alignErrW=1.
  - no memop: stallM=0; W pass-through with memdataW=0.
- ACCESS:
  - dm_req=1; dm_we=memwriteM; dm_addr, dm_be, dm_wdata are driven from the current M inputs, which are stable because of the stall.
  - dm_ack=1: stallM=0 this cycle. At the edge, W captures the op with memdataW formatted, then next state IDLE.
  - No ack and cnt==TIMEOUT-1: stallM=0; W gets regwriteW=0, busErrW=1; next state IDLE.
  - Otherwise: stallM=1, cnt++.
  - Ack and timeout in the same cycle: ack wins.
- Stores:
  - word: be=1111, wdata=qbM.
  - half: be = addr[1] ? 1100 : 0011, wdata={2{qbM[15:0]}}.
  - byte: be = 0001<<addr[1:0], wdata={4{qbM[7:0]}}.
  - be=0000 whenever dm_req=0.
- Loads: select the lane by addr[1:0]; sign- or zero-extend per wtypeM. Store completion writes memdataW=0.
- W register:
  - Updates every cycle.
  - On any stalled cycle it loads a bubble: regwriteW=0, memtoregW=0, error pulses 0. Other W fields hold.
  - Error pulses last exactly one cycle.
- dm_ack in IDLE is ignored.
- Latency: an acked access whose ack arrives k cycles after ACCESS entry stalls for k+1 cycles. W is valid on the cycle after the ack.
- Reset (including mid-ACCESS):
  - state IDLE, cnt=0.
  - All W outputs and error pulses 0; dm_req=0 from the next cycle.
  - A late ack after reset is ignored.

Test Plan:
1. Word load: ALUoutM=0x100, wtype=000; dm_ack 2 cycles after dm_req with rdata=0xDEADBEEF -> stallM high for 3 cycles; next cycle regwriteW=1, memtoregW=1, memdataW=0xDEADBEEF.
2. Byte store: ALUoutM=0x203, qbM=0x000000A5, wtype=011 -> dm_addr=0x200, dm_be=1000, dm_wdata=0xA5A5A5A5, dm_we=1.
3. Signed and unsigned half loads: rdata=0x8001F00F at addr 0x102. wtype=001 -> memdataW=0xFFFF8001. wtype=010 -> 0x00008001.
4. Misaligned: word load at addr 0x101 -> no dm_req, stallM=0, alignErrW pulse, regwriteW=0.
5. Timeout: TIMEOUT=16 with ack never asserted -> dm_req high exactly 16 cycles, then busErrW pulse and stallM low. An ack on cycle 16 instead completes normally with no busErrW.
6. Reset mid-ACCESS after 3 wait cycles -> next cycle dm_req=0, stallM=0, W outputs 0. A subsequent stray dm_ack produces no W write.
